// File: rtl/hyperbus_phy_mux.sv
// Purpose : routes AXI/uDMA transaction descriptors to the hyperbus PHY through a one-entry
//           slice, and steers TX/RX beats to and from the master that owns the oldest
//           outstanding transaction, tracked in an owner FIFO.
// Latency : descriptor 1 cycle (input handshake -> phy_trans_valid_o); TX/RX beats 0 cycles.
// Backpr. : trans_ready follows the slice (full throughput when the PHY is ready); descriptor
//           issue stalls while the owner FIFO is full; TX/RX readies pass straight through the
//           head master and are 0 while nothing is outstanding.
// Ports   : clk_i/rst_ni; sel_i arbiter select (0 AXI, 1 uDMA); {axi,udma}_trans_* descriptor
//           inputs; phy_trans_* descriptor output; {axi,udma}_tx_* -> phy_tx_*;
//           phy_rx_* -> {axi,udma}_rx_*.
module hyperbus_phy_mux #(
    parameter int unsigned TRANS_W     = 48,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sel_i,
    // transaction descriptors
    input  logic                axi_trans_valid_i,
    output logic                axi_trans_ready_o,
    input  logic [TRANS_W-1:0]  axi_trans_i,
    input  logic                udma_trans_valid_i,
    output logic                udma_trans_ready_o,
    input  logic [TRANS_W-1:0]  udma_trans_i,
    output logic                phy_trans_valid_o,
    input  logic                phy_trans_ready_i,
    output logic [TRANS_W-1:0]  phy_trans_o,
    // TX beats (masters -> PHY)
    input  logic                axi_tx_valid_i,
    output logic                axi_tx_ready_o,
    input  logic [DATA_W-1:0]   axi_tx_data_i,
    input  logic [DATA_W/8-1:0] axi_tx_strb_i,
    input  logic                axi_tx_last_i,
    input  logic                udma_tx_valid_i,
    output logic                udma_tx_ready_o,
    input  logic [DATA_W-1:0]   udma_tx_data_i,
    input  logic [DATA_W/8-1:0] udma_tx_strb_i,
    input  logic                udma_tx_last_i,
    output logic                phy_tx_valid_o,
    input  logic                phy_tx_ready_i,
    output logic [DATA_W-1:0]   phy_tx_data_o,
    output logic [DATA_W/8-1:0] phy_tx_strb_o,
    output logic                phy_tx_last_o,
    // RX beats (PHY -> masters)
    input  logic                phy_rx_valid_i,
    output logic                phy_rx_ready_o,
    input  logic [DATA_W-1:0]   phy_rx_data_i,
    input  logic                phy_rx_last_i,
    input  logic                phy_rx_error_i,
    output logic                axi_rx_valid_o,
    input  logic                axi_rx_ready_i,
    output logic [DATA_W-1:0]   axi_rx_data_o,
    output logic                axi_rx_last_o,
    output logic                axi_rx_error_o,
    output logic                udma_rx_valid_o,
    input  logic                udma_rx_ready_i,
    output logic [DATA_W-1:0]   udma_rx_data_o,
    output logic                udma_rx_last_o,
    output logic                udma_rx_error_o
);

    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

    // Held low during reset and for the first cycle after it, so no descriptor
    // ready is presented while the block is in reset.
    logic                   en_q;

    logic                   slice_vld_q, slice_vld_d;
    logic                   slice_tag_q, slice_tag_d;
    logic [TRANS_W-1:0]     slice_dat_q, slice_dat_d;

    logic [OUTSTANDING-1:0] owner_q, owner_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic fifo_full, fifo_empty, head_tag;
    logic slice_rdy, in_hs, push, pop, tx_pop, rx_pop;

    assign fifo_full  = (cnt_q == CNT_W'(OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head_tag   = owner_q[rd_ptr_q];

    // ---------------- transaction slice ----------------
    // Issue is gated by the registered full flag only; a retire in the same
    // cycle frees the slot for the next cycle, keeping pop off this path.
    assign phy_trans_valid_o  = slice_vld_q & ~fifo_full;
    assign phy_trans_o        = slice_dat_q;
    assign push               = phy_trans_valid_o & phy_trans_ready_i;
    assign slice_rdy          = en_q & (~slice_vld_q | push);
    assign axi_trans_ready_o  = slice_rdy & ~sel_i;
    assign udma_trans_ready_o = slice_rdy & sel_i;
    assign in_hs              = sel_i ? (udma_trans_valid_i & udma_trans_ready_o)
                                      : (axi_trans_valid_i & axi_trans_ready_o);

    always_comb begin
        slice_vld_d = slice_vld_q;
        slice_tag_d = slice_tag_q;
        slice_dat_d = slice_dat_q;
        if (in_hs) begin
            slice_vld_d = 1'b1;
            slice_tag_d = sel_i;
            slice_dat_d = sel_i ? udma_trans_i : axi_trans_i;
        end else if (push) begin
            slice_vld_d = 1'b0;
        end
    end

    // ---------------- TX routing ----------------
    always_comb begin
        phy_tx_valid_o  = 1'b0;
        phy_tx_data_o   = '0;
        phy_tx_strb_o   = '0;
        phy_tx_last_o   = 1'b0;
        axi_tx_ready_o  = 1'b0;
        udma_tx_ready_o = 1'b0;
        if (!fifo_empty) begin
            if (head_tag) begin
                phy_tx_valid_o  = udma_tx_valid_i;
                phy_tx_data_o   = udma_tx_data_i;
                phy_tx_strb_o   = udma_tx_strb_i;
                phy_tx_last_o   = udma_tx_last_i;
                udma_tx_ready_o = phy_tx_ready_i;
            end else begin
                phy_tx_valid_o  = axi_tx_valid_i;
                phy_tx_data_o   = axi_tx_data_i;
                phy_tx_strb_o   = axi_tx_strb_i;
                phy_tx_last_o   = axi_tx_last_i;
                axi_tx_ready_o  = phy_tx_ready_i;
            end
        end
    end

    // ---------------- RX routing ----------------
    // Payload is broadcast; only valid is steered to the owner.
    assign phy_rx_ready_o  = ~fifo_empty & (head_tag ? udma_rx_ready_i : axi_rx_ready_i);
    assign axi_rx_valid_o  = phy_rx_valid_i & ~fifo_empty & ~head_tag;
    assign udma_rx_valid_o = phy_rx_valid_i & ~fifo_empty & head_tag;
    assign axi_rx_data_o   = phy_rx_data_i;
    assign axi_rx_last_o   = phy_rx_last_i;
    assign axi_rx_error_o  = phy_rx_error_i;
    assign udma_rx_data_o  = phy_rx_data_i;
    assign udma_rx_last_o  = phy_rx_last_i;
    assign udma_rx_error_o = phy_rx_error_i;

    // ---------------- owner FIFO ----------------
    // A TX and an RX last beat in the same cycle still retire a single entry.
    assign tx_pop = phy_tx_valid_o & phy_tx_ready_i & phy_tx_last_o;
    assign rx_pop = phy_rx_valid_i & phy_rx_ready_o & phy_rx_last_i;
    assign pop    = tx_pop | rx_pop;

    always_comb begin
        owner_d  = owner_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            owner_d[wr_ptr_q] = slice_tag_q;
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q        <= 1'b0;
            slice_vld_q <= 1'b0;
            slice_tag_q <= 1'b0;
            slice_dat_q <= '0;
            owner_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            en_q        <= 1'b1;
            slice_vld_q <= slice_vld_d;
            slice_tag_q <= slice_tag_d;
            slice_dat_q <= slice_dat_d;
            owner_q     <= owner_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hyperbus_phy_mux.sv
// Purpose : self-checking bench for hyperbus_phy_mux: directed scenarios plus a randomized
//           run checked against a queue-based reference model.
// Latency : n/a (testbench).
// Backpr. : n/a (testbench).
module tb_hyperbus_phy_mux;

    localparam int TW  = 48;
    localparam int DW  = 16;
    localparam int SW  = DW / 8;
    localparam int OUT = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          sel_i;
    logic          axi_trans_valid_i, axi_trans_ready_o;
    logic [TW-1:0] axi_trans_i;
    logic          udma_trans_valid_i, udma_trans_ready_o;
    logic [TW-1:0] udma_trans_i;
    logic          phy_trans_valid_o, phy_trans_ready_i;
    logic [TW-1:0] phy_trans_o;
    logic          axi_tx_valid_i, axi_tx_ready_o, axi_tx_last_i;
    logic [DW-1:0] axi_tx_data_i;
    logic [SW-1:0] axi_tx_strb_i;
    logic          udma_tx_valid_i, udma_tx_ready_o, udma_tx_last_i;
    logic [DW-1:0] udma_tx_data_i;
    logic [SW-1:0] udma_tx_strb_i;
    logic          phy_tx_valid_o, phy_tx_ready_i, phy_tx_last_o;
    logic [DW-1:0] phy_tx_data_o;
    logic [SW-1:0] phy_tx_strb_o;
    logic          phy_rx_valid_i, phy_rx_ready_o, phy_rx_last_i, phy_rx_error_i;
    logic [DW-1:0] phy_rx_data_i;
    logic          axi_rx_valid_o, axi_rx_ready_i, axi_rx_last_o, axi_rx_error_o;
    logic [DW-1:0] axi_rx_data_o;
    logic          udma_rx_valid_o, udma_rx_ready_i, udma_rx_last_o, udma_rx_error_o;
    logic [DW-1:0] udma_rx_data_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    hyperbus_phy_mux #(.TRANS_W(TW), .DATA_W(DW), .OUTSTANDING(OUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sel_i(sel_i),
        .axi_trans_valid_i(axi_trans_valid_i), .axi_trans_ready_o(axi_trans_ready_o),
        .axi_trans_i(axi_trans_i),
        .udma_trans_valid_i(udma_trans_valid_i), .udma_trans_ready_o(udma_trans_ready_o),
        .udma_trans_i(udma_trans_i),
        .phy_trans_valid_o(phy_trans_valid_o), .phy_trans_ready_i(phy_trans_ready_i),
        .phy_trans_o(phy_trans_o),
        .axi_tx_valid_i(axi_tx_valid_i), .axi_tx_ready_o(axi_tx_ready_o),
        .axi_tx_data_i(axi_tx_data_i), .axi_tx_strb_i(axi_tx_strb_i), .axi_tx_last_i(axi_tx_last_i),
        .udma_tx_valid_i(udma_tx_valid_i), .udma_tx_ready_o(udma_tx_ready_o),
        .udma_tx_data_i(udma_tx_data_i), .udma_tx_strb_i(udma_tx_strb_i), .udma_tx_last_i(udma_tx_last_i),
        .phy_tx_valid_o(phy_tx_valid_o), .phy_tx_ready_i(phy_tx_ready_i),
        .phy_tx_data_o(phy_tx_data_o), .phy_tx_strb_o(phy_tx_strb_o), .phy_tx_last_o(phy_tx_last_o),
        .phy_rx_valid_i(phy_rx_valid_i), .phy_rx_ready_o(phy_rx_ready_o),
        .phy_rx_data_i(phy_rx_data_i), .phy_rx_last_i(phy_rx_last_i), .phy_rx_error_i(phy_rx_error_i),
        .axi_rx_valid_o(axi_rx_valid_o), .axi_rx_ready_i(axi_rx_ready_i),
        .axi_rx_data_o(axi_rx_data_o), .axi_rx_last_o(axi_rx_last_o), .axi_rx_error_o(axi_rx_error_o),
        .udma_rx_valid_o(udma_rx_valid_o), .udma_rx_ready_i(udma_rx_ready_i),
        .udma_rx_data_o(udma_rx_data_o), .udma_rx_last_o(udma_rx_last_o), .udma_rx_error_o(udma_rx_error_o)
    );

    // All handshake outputs packed together so reset checks look at every one.
    logic [8:0] hs_outs;
    assign hs_outs = {phy_trans_valid_o, axi_trans_ready_o, udma_trans_ready_o,
                      phy_tx_valid_o, axi_tx_ready_o, udma_tx_ready_o,
                      phy_rx_ready_o, axi_rx_valid_o, udma_rx_valid_o};

    task automatic idle();
        sel_i = 1'b0;
        axi_trans_valid_i = 1'b0;  axi_trans_i = '0;
        udma_trans_valid_i = 1'b0; udma_trans_i = '0;
        phy_trans_ready_i = 1'b0;
        axi_tx_valid_i = 1'b0;  axi_tx_data_i = '0;  axi_tx_strb_i = '0;  axi_tx_last_i = 1'b0;
        udma_tx_valid_i = 1'b0; udma_tx_data_i = '0; udma_tx_strb_i = '0; udma_tx_last_i = 1'b0;
        phy_tx_ready_i = 1'b0;
        phy_rx_valid_i = 1'b0; phy_rx_data_i = '0; phy_rx_last_i = 1'b0; phy_rx_error_i = 1'b0;
        axi_rx_ready_i = 1'b0; udma_rx_ready_i = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
    endtask

    // Pushes three AXI descriptors 0xD0..0xD2 with the PHY always ready; leaves
    // two in the owner FIFO and the third waiting in the slice.
    task automatic fill_three(output int n);
        logic hs;
        n = 0;
        sel_i = 1'b0;
        phy_trans_ready_i = 1'b1;
        axi_trans_valid_i = 1'b1;
        axi_trans_i = 48'hD0;
        for (int k = 0; k < 10 && n < 3; k++) begin
            @(negedge clk_i);
            hs = axi_trans_ready_o;
            cyc();
            if (hs) begin
                n++;
                axi_trans_i = 48'hD0 + 48'(n);
            end
            if (n == 3) axi_trans_valid_i = 1'b0;
        end
        axi_trans_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        axi_trans_valid_i = 1'b1; udma_trans_valid_i = 1'b1; phy_trans_ready_i = 1'b1;
        axi_tx_valid_i = 1'b1; udma_tx_valid_i = 1'b1; phy_tx_ready_i = 1'b1;
        axi_tx_data_i = 16'hFFFF; axi_tx_strb_i = '1; axi_tx_last_i = 1'b1;
        phy_rx_valid_i = 1'b1; axi_rx_ready_i = 1'b1; udma_rx_ready_i = 1'b1;
        #3;
        tests++;
        if (hs_outs !== 9'b0) begin
            fails++; $display("FAIL reset_handshakes: got %b expected 0", hs_outs);
        end
        tests++;
        if ({phy_trans_o, phy_tx_data_o, phy_tx_strb_o, phy_tx_last_o} !== '0) begin
            fails++; $display("FAIL reset_data: trans=%h tx=%h strb=%h last=%b expected all 0",
                              phy_trans_o, phy_tx_data_o, phy_tx_strb_o, phy_tx_last_o);
        end
        cyc();
        tests++;
        if (hs_outs !== 9'b0) begin
            fails++; $display("FAIL reset_held: got %b expected 0 after clock edge in reset", hs_outs);
        end
        do_reset();
    endtask

    task automatic test_single_issue();
        do_reset();
        sel_i = 1'b0;
        axi_trans_valid_i = 1'b1; axi_trans_i = 48'h0000_1234_5678;
        udma_trans_valid_i = 1'b1; udma_trans_i = 48'hFFFF_FFFF_FFFF;
        phy_trans_ready_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if ({axi_trans_ready_o, udma_trans_ready_o, phy_trans_valid_o} !== 3'b100) begin
            fails++; $display("FAIL single_accept: axi_rdy/udma_rdy/phy_vld=%b expected 100",
                              {axi_trans_ready_o, udma_trans_ready_o, phy_trans_valid_o});
        end
        cyc();
        axi_trans_valid_i = 1'b0; udma_trans_valid_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (phy_trans_valid_o !== 1'b1 || phy_trans_o !== 48'h0000_1234_5678 || udma_trans_ready_o !== 1'b0) begin
            fails++; $display("FAIL single_issue: vld=%b desc=%h udma_rdy=%b expected 1 000012345678 0",
                              phy_trans_valid_o, phy_trans_o, udma_trans_ready_o);
        end
        cyc();
        phy_rx_valid_i = 1'b1; phy_rx_last_i = 1'b1; phy_rx_data_i = 16'h1111; axi_rx_ready_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if ({axi_rx_valid_o, udma_rx_valid_o, phy_rx_ready_o, phy_trans_valid_o} !== 4'b1010) begin
            fails++; $display("FAIL single_retire: axi_rxv/udma_rxv/phy_rxr/phy_tv=%b expected 1010",
                              {axi_rx_valid_o, udma_rx_valid_o, phy_rx_ready_o, phy_trans_valid_o});
        end
        cyc();
        idle();
    endtask

    task automatic test_outstanding_limit();
        int n;
        do_reset();
        fill_three(n);
        tests++;
        if (n !== 3) begin
            fails++; $display("FAIL limit_fill: accepted %0d descriptors expected 3 within budget", n);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            tests++;
            if (phy_trans_valid_o !== 1'b0) begin
                fails++; $display("FAIL limit_stall: cycle %0d phy_trans_valid=%b expected 0", k, phy_trans_valid_o);
            end
            cyc();
        end
        phy_rx_valid_i = 1'b1; phy_rx_last_i = 1'b1; axi_rx_ready_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if (phy_rx_ready_o !== 1'b1 || phy_trans_valid_o !== 1'b0) begin
            fails++; $display("FAIL limit_pop_cycle: rx_rdy=%b trans_vld=%b expected 1 0",
                              phy_rx_ready_o, phy_trans_valid_o);
        end
        cyc();
        phy_rx_valid_i = 1'b0; phy_rx_last_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (phy_trans_valid_o !== 1'b1 || phy_trans_o !== 48'hD2) begin
            fails++; $display("FAIL limit_release: vld=%b desc=%h expected 1 d2", phy_trans_valid_o, phy_trans_o);
        end
        cyc();
        idle();
    endtask

    task automatic test_routing();
        do_reset();
        phy_trans_ready_i = 1'b1;
        sel_i = 1'b1; udma_trans_valid_i = 1'b1; udma_trans_i = 48'hAA;
        @(negedge clk_i);
        tests++;
        if (udma_trans_ready_o !== 1'b1) begin
            fails++; $display("FAIL route_udma_accept: got %b expected 1", udma_trans_ready_o);
        end
        cyc();
        sel_i = 1'b0; udma_trans_valid_i = 1'b0; axi_trans_valid_i = 1'b1; axi_trans_i = 48'hBB;
        @(negedge clk_i);
        tests++;
        if (axi_trans_ready_o !== 1'b1) begin
            fails++; $display("FAIL route_axi_accept: got %b expected 1", axi_trans_ready_o);
        end
        cyc();
        axi_trans_valid_i = 1'b0;
        cyc();
        axi_tx_valid_i = 1'b1; axi_tx_data_i = 16'hA5A5; axi_tx_strb_i = 2'b11;
        phy_tx_ready_i = 1'b1; axi_rx_ready_i = 1'b1; udma_rx_ready_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            phy_rx_valid_i = 1'b1; phy_rx_data_i = 16'h0100 + 16'(b); phy_rx_last_i = (b == 3);
            @(negedge clk_i);
            tests++;
            if ({udma_rx_valid_o, axi_rx_valid_o} !== 2'b10 || udma_rx_data_o !== 16'h0100 + 16'(b)
                || udma_rx_last_o !== (b == 3)) begin
                fails++; $display("FAIL route_rx beat %0d: udma_v/axi_v=%b data=%h last=%b expected 10 %h %b",
                                  b, {udma_rx_valid_o, axi_rx_valid_o}, udma_rx_data_o, udma_rx_last_o,
                                  16'h0100 + 16'(b), (b == 3));
            end
            tests++;
            if ({axi_tx_ready_o, phy_tx_valid_o} !== 2'b00) begin
                fails++; $display("FAIL route_tx_blocked beat %0d: axi_tx_rdy/phy_tx_vld=%b expected 00",
                                  b, {axi_tx_ready_o, phy_tx_valid_o});
            end
            cyc();
        end
        phy_rx_valid_i = 1'b0; phy_rx_last_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            axi_tx_data_i = 16'hC000 + 16'(b); axi_tx_last_i = (b == 1);
            @(negedge clk_i);
            tests++;
            if (phy_tx_valid_o !== 1'b1 || phy_tx_data_o !== 16'hC000 + 16'(b) || phy_tx_strb_o !== 2'b11
                || phy_tx_last_o !== (b == 1) || axi_tx_ready_o !== 1'b1 || udma_tx_ready_o !== 1'b0) begin
                fails++; $display("FAIL route_tx beat %0d: vld=%b data=%h strb=%b last=%b axi_rdy=%b udma_rdy=%b expected 1 %h 11 %b 1 0",
                                  b, phy_tx_valid_o, phy_tx_data_o, phy_tx_strb_o, phy_tx_last_o,
                                  axi_tx_ready_o, udma_tx_ready_o, 16'hC000 + 16'(b), (b == 1));
            end
            cyc();
        end
        axi_tx_last_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({phy_tx_valid_o, axi_tx_ready_o, phy_tx_data_o} !== '0) begin
            fails++; $display("FAIL route_empty: vld=%b rdy=%b data=%h expected all 0",
                              phy_tx_valid_o, axi_tx_ready_o, phy_tx_data_o);
        end
        idle();
    endtask

    task automatic test_rx_backpressure();
        do_reset();
        sel_i = 1'b1; udma_trans_valid_i = 1'b1; udma_trans_i = 48'h77; phy_trans_ready_i = 1'b1;
        cyc();
        udma_trans_valid_i = 1'b0;
        cyc();
        phy_rx_valid_i = 1'b1; phy_rx_data_i = 16'hBEEF; phy_rx_last_i = 1'b1;
        udma_rx_ready_i = 1'b0; axi_rx_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            tests++;
            if (phy_rx_ready_o !== 1'b0 || udma_rx_valid_o !== 1'b1 || axi_rx_valid_o !== 1'b0
                || udma_rx_data_o !== 16'hBEEF) begin
                fails++; $display("FAIL rx_stall cycle %0d: rdy=%b udma_v=%b axi_v=%b data=%h expected 0 1 0 beef",
                                  k, phy_rx_ready_o, udma_rx_valid_o, axi_rx_valid_o, udma_rx_data_o);
            end
            cyc();
        end
        udma_rx_ready_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if (phy_rx_ready_o !== 1'b1 || udma_rx_valid_o !== 1'b1) begin
            fails++; $display("FAIL rx_deliver: rdy=%b udma_v=%b expected 1 1", phy_rx_ready_o, udma_rx_valid_o);
        end
        cyc();
        @(negedge clk_i);
        tests++;
        if (phy_rx_ready_o !== 1'b0 || udma_rx_valid_o !== 1'b0) begin
            fails++; $display("FAIL rx_once: rdy=%b udma_v=%b expected 0 0", phy_rx_ready_o, udma_rx_valid_o);
        end
        idle();
    endtask

    // One descriptor per cycle while the previous one retires in the same cycle:
    // occupancy stays at one and the pointers wrap several times.
    task automatic test_back_to_back();
        bit own[10];
        bit o;
        do_reset();
        phy_trans_ready_i = 1'b1; axi_rx_ready_i = 1'b1; udma_rx_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) own[i] = 1'($urandom_range(0, 1));
        for (int c = 0; c < 12; c++) begin
            if (c < 10) begin
                sel_i = own[c];
                axi_trans_valid_i = !own[c]; udma_trans_valid_i = own[c];
                axi_trans_i = 48'h100 + 48'(c); udma_trans_i = 48'h100 + 48'(c);
            end else begin
                axi_trans_valid_i = 1'b0; udma_trans_valid_i = 1'b0;
            end
            phy_rx_valid_i = (c >= 2); phy_rx_last_i = (c >= 2);
            phy_rx_data_i = 16'h200 + 16'(c);
            @(negedge clk_i);
            if (c < 10) begin
                tests++;
                if ((own[c] ? udma_trans_ready_o : axi_trans_ready_o) !== 1'b1) begin
                    fails++; $display("FAIL b2b_accept c=%0d: selected ready=0 expected 1", c);
                end
            end
            if (c >= 1 && c <= 10) begin
                tests++;
                if (phy_trans_valid_o !== 1'b1 || phy_trans_o !== 48'h100 + 48'(c - 1)) begin
                    fails++; $display("FAIL b2b_issue c=%0d: vld=%b desc=%h expected 1 %h",
                                      c, phy_trans_valid_o, phy_trans_o, 48'h100 + 48'(c - 1));
                end
            end
            if (c >= 2) begin
                o = own[c - 2];
                tests++;
                if ({axi_rx_valid_o, udma_rx_valid_o} !== {!o, o} || phy_rx_ready_o !== 1'b1) begin
                    fails++; $display("FAIL b2b_owner c=%0d: axi_v/udma_v=%b rdy=%b expected %b 1",
                                      c, {axi_rx_valid_o, udma_rx_valid_o}, phy_rx_ready_o, {!o, o});
                end
            end
            cyc();
        end
        @(negedge clk_i);
        tests++;
        if ({phy_rx_ready_o, axi_rx_valid_o, udma_rx_valid_o} !== 3'b000) begin
            fails++; $display("FAIL b2b_drain: rdy/axi_v/udma_v=%b expected 000",
                              {phy_rx_ready_o, axi_rx_valid_o, udma_rx_valid_o});
        end
        idle();
    endtask

    task automatic test_reset_midburst();
        int n;
        do_reset();
        fill_three(n);
        axi_trans_valid_i = 1'b1; axi_trans_i = 48'hEE;
        axi_tx_valid_i = 1'b1; axi_tx_data_i = 16'h1234; phy_tx_ready_i = 1'b1;
        phy_rx_valid_i = 1'b1; axi_rx_ready_i = 1'b1; phy_trans_ready_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if (n !== 3 || {phy_tx_valid_o, phy_rx_ready_o, axi_rx_valid_o, phy_trans_valid_o} !== 4'b1110) begin
            fails++; $display("FAIL midrst_pre: n=%0d tx_v/rx_r/axi_rx_v/trans_v=%b expected 3 1110",
                              n, {phy_tx_valid_o, phy_rx_ready_o, axi_rx_valid_o, phy_trans_valid_o});
        end
        #2;
        rst_ni = 1'b0;
        #1;
        tests++;
        if (hs_outs !== 9'b0 || phy_trans_o !== '0 || phy_tx_data_o !== '0) begin
            fails++; $display("FAIL midrst_clear: hs=%b desc=%h tx_data=%h expected 0 0 0",
                              hs_outs, phy_trans_o, phy_tx_data_o);
        end
        idle();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
        sel_i = 1'b0; axi_trans_valid_i = 1'b1; axi_trans_i = 48'h0ABC; phy_trans_ready_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if (axi_trans_ready_o !== 1'b1 || phy_trans_valid_o !== 1'b0) begin
            fails++; $display("FAIL midrst_accept: rdy=%b vld=%b expected 1 0", axi_trans_ready_o, phy_trans_valid_o);
        end
        cyc();
        axi_trans_valid_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (phy_trans_valid_o !== 1'b1 || phy_trans_o !== 48'h0ABC) begin
            fails++; $display("FAIL midrst_issue: vld=%b desc=%h expected 1 abc", phy_trans_valid_o, phy_trans_o);
        end
        cyc();
        axi_tx_valid_i = 1'b1; axi_tx_last_i = 1'b1; phy_tx_ready_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if (phy_tx_valid_o !== 1'b1 || axi_tx_ready_o !== 1'b1) begin
            fails++; $display("FAIL midrst_tx: vld=%b rdy=%b expected 1 1", phy_tx_valid_o, axi_tx_ready_o);
        end
        cyc();
        @(negedge clk_i);
        tests++;
        if (phy_tx_valid_o !== 1'b0) begin
            fails++; $display("FAIL midrst_stale: phy_tx_valid=%b expected 0 (old entries discarded)", phy_tx_valid_o);
        end
        idle();
    endtask

    // Random traffic against a model: a one-slot descriptor holder and a queue of owners.
    task automatic test_random();
        bit            m_full = 0;
        bit            m_tag = 0;
        logic [TW-1:0] m_desc = '0;
        bit            oq[$];
        bit            empty, head, e_pv, e_sr, e_ptv, e_ptl, e_prr, pop, push, in_hs;
        logic [DW-1:0] e_ptd;
        logic [SW-1:0] e_pts;
        do_reset();
        for (int cy = 0; cy < 3000; cy++) begin
            sel_i = 1'($urandom);
            axi_trans_valid_i = 1'($urandom);  axi_trans_i = 48'({$urandom(), $urandom()});
            udma_trans_valid_i = 1'($urandom); udma_trans_i = 48'({$urandom(), $urandom()});
            phy_trans_ready_i = ($urandom_range(0, 3) != 0);
            axi_tx_valid_i = 1'($urandom); axi_tx_data_i = 16'($urandom); axi_tx_strb_i = 2'($urandom);
            axi_tx_last_i = ($urandom_range(0, 2) == 0);
            udma_tx_valid_i = 1'($urandom); udma_tx_data_i = 16'($urandom); udma_tx_strb_i = 2'($urandom);
            udma_tx_last_i = ($urandom_range(0, 2) == 0);
            phy_tx_ready_i = 1'($urandom);
            phy_rx_valid_i = 1'($urandom); phy_rx_data_i = 16'($urandom);
            phy_rx_last_i = ($urandom_range(0, 2) == 0); phy_rx_error_i = 1'($urandom);
            axi_rx_ready_i = 1'($urandom); udma_rx_ready_i = 1'($urandom);

            empty = (oq.size() == 0);
            head  = empty ? 1'b0 : oq[0];
            e_pv  = m_full && (oq.size() < OUT);
            e_sr  = !m_full || (e_pv && phy_trans_ready_i);
            e_ptv = !empty && (head ? udma_tx_valid_i : axi_tx_valid_i);
            e_ptd = empty ? '0 : (head ? udma_tx_data_i : axi_tx_data_i);
            e_pts = empty ? '0 : (head ? udma_tx_strb_i : axi_tx_strb_i);
            e_ptl = !empty && (head ? udma_tx_last_i : axi_tx_last_i);
            e_prr = !empty && (head ? udma_rx_ready_i : axi_rx_ready_i);

            @(negedge clk_i);
            tests++;
            if ({phy_trans_valid_o, axi_trans_ready_o, udma_trans_ready_o, phy_trans_o}
                !== {e_pv, e_sr && !sel_i, e_sr && sel_i, m_desc}) begin
                fails++; $display("FAIL rand_trans cy=%0d: vld/ardy/urdy=%b desc=%h expected %b %h", cy,
                                  {phy_trans_valid_o, axi_trans_ready_o, udma_trans_ready_o}, phy_trans_o,
                                  {e_pv, e_sr && !sel_i, e_sr && sel_i}, m_desc);
            end
            tests++;
            if ({phy_tx_valid_o, phy_tx_data_o, phy_tx_strb_o, phy_tx_last_o, axi_tx_ready_o, udma_tx_ready_o}
                !== {e_ptv, e_ptd, e_pts, e_ptl, !empty && !head && phy_tx_ready_i, !empty && head && phy_tx_ready_i}) begin
                fails++; $display("FAIL rand_tx cy=%0d: vld=%b data=%h strb=%b last=%b ardy=%b urdy=%b expected %b %h %b %b %b %b",
                                  cy, phy_tx_valid_o, phy_tx_data_o, phy_tx_strb_o, phy_tx_last_o, axi_tx_ready_o,
                                  udma_tx_ready_o, e_ptv, e_ptd, e_pts, e_ptl, !empty && !head && phy_tx_ready_i,
                                  !empty && head && phy_tx_ready_i);
            end
            tests++;
            if ({phy_rx_ready_o, axi_rx_valid_o, udma_rx_valid_o} !==
                {e_prr, phy_rx_valid_i && !empty && !head, phy_rx_valid_i && !empty && head}
                || {axi_rx_data_o, axi_rx_last_o, axi_rx_error_o} !== {phy_rx_data_i, phy_rx_last_i, phy_rx_error_i}
                || {udma_rx_data_o, udma_rx_last_o, udma_rx_error_o} !== {phy_rx_data_i, phy_rx_last_i, phy_rx_error_i}) begin
                fails++; $display("FAIL rand_rx cy=%0d: rdy/av/uv=%b expected %b (payload must mirror phy)", cy,
                                  {phy_rx_ready_o, axi_rx_valid_o, udma_rx_valid_o},
                                  {e_prr, phy_rx_valid_i && !empty && !head, phy_rx_valid_i && !empty && head});
            end

            pop   = (e_ptv && phy_tx_ready_i && e_ptl) || (phy_rx_valid_i && e_prr && phy_rx_last_i);
            push  = e_pv && phy_trans_ready_i;
            in_hs = sel_i ? (udma_trans_valid_i && e_sr) : (axi_trans_valid_i && e_sr);
            if (pop) void'(oq.pop_front());
            if (push) oq.push_back(m_tag);
            if (in_hs) begin
                m_full = 1'b1;
                m_tag  = sel_i;
                m_desc = sel_i ? udma_trans_i : axi_trans_i;
            end else if (push) begin
                m_full = 1'b0;
            end
            cyc();
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_issue();
        test_outstanding_limit();
        test_routing();
        test_rx_backpressure();
        test_back_to_back();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
